// File: rtl/ctrl_pkg.sv
// Shared constants and types for the multicycle control unit: opcode and
// function-code encodings, the default pass-through ALU operation and the
// FSM state enumeration.
package ctrl_pkg;

  localparam logic [4:0] OP_AR   = 5'b00010;
  localparam logic [4:0] OP_T    = 5'b01011;
  localparam logic [4:0] OP_LD   = 5'b00100;
  localparam logic [4:0] OP_ST   = 5'b00101;
  localparam logic [4:0] OP_HALT = 5'b11111;

  localparam logic [3:0] FN_ADD = 4'b0000;
  localparam logic [3:0] FN_SUB = 4'b0001;
  localparam logic [3:0] FN_AND = 4'b0010;
  localparam logic [3:0] FN_OR  = 4'b0011;
  localparam logic [3:0] FN_XOR = 4'b0100;
  localparam logic [3:0] FN_NOR = 4'b0101;
  localparam logic [3:0] FN_SLT = 4'b0110;
  localparam logic [3:0] FN_SLL = 4'b0111;
  localparam logic [3:0] FN_SRL = 4'b1000;

  localparam logic [3:0] ALU_PASS = 4'b1111;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5,
    TRAP   = 3'd6
  } state_t;

endpackage

// File: rtl/multicycle_control_unit_if.sv
// Bundle between the control unit and the datapath/memory side.
// Handshake: mem_ready is sampled only while the unit is in FETCH or MEM with
// its memRead/memWrite strobe high; a strobe stays asserted every cycle until
// the cycle in which mem_ready is also high, and that cycle completes the
// access. mem_ready in any other state is ignored.
// modport master = control unit, modport slave = datapath/memory side.
interface multicycle_control_unit_if #(
  parameter int OPW  = 5,
  parameter int FNW  = 4,
  parameter int ALUW = 4
);

  logic [OPW-1:0]  opcode;
  logic [FNW-1:0]  funct;
  logic            mem_ready;
  logic [ALUW-1:0] ALUop;
  logic            regWrite;
  logic            muxWriteReg;
  logic            muxWriteData;
  logic            pcWrite;
  logic            irWrite;
  logic            memRead;
  logic            memWrite;
  logic            halted;
  logic            illegal;

  modport master (
    input  opcode, funct, mem_ready,
    output ALUop, regWrite, muxWriteReg, muxWriteData, pcWrite, irWrite,
           memRead, memWrite, halted, illegal
  );

  modport slave (
    output opcode, funct, mem_ready,
    input  ALUop, regWrite, muxWriteReg, muxWriteData, pcWrite, irWrite,
           memRead, memWrite, halted, illegal
  );

endinterface

// File: rtl/ctrl_out_decode.sv
// Combinational output decode: maps the current state plus the latched
// opcode/funct to every control strobe. blank forces all outputs low (used
// while reset is held).
module ctrl_out_decode
  import ctrl_pkg::*;
#(
  parameter int              OPW      = 5,
  parameter int              FNW      = 4,
  parameter int              ALUW     = 4,
  parameter logic [ALUW-1:0] PASS_OP  = ALUW'(ctrl_pkg::ALU_PASS)
) (
  input  state_t          state,
  input  logic [OPW-1:0]  op,
  input  logic [FNW-1:0]  funct,
  input  logic            mem_ready,
  input  logic            illegal_flag,
  input  logic            blank,
  output logic [ALUW-1:0] alu_op,
  output logic            reg_write,
  output logic            mux_write_reg,
  output logic            mux_write_data,
  output logic            pc_write,
  output logic            ir_write,
  output logic            mem_read,
  output logic            mem_write,
  output logic            halted,
  output logic            illegal
);

  logic is_ar;
  logic is_ld;
  logic [ALUW-1:0] exec_alu_op;

  assign is_ar = (op == OPW'(OP_AR));
  assign is_ld = (op == OPW'(OP_LD));
  // AR uses the zero-extended function code, everything else passes through.
  assign exec_alu_op = is_ar ? ALUW'(funct) : PASS_OP;

  // Per-state strobe decode; ALUop holds its EXEC value through MEM and WB.
  always_comb begin
    alu_op         = '0;
    reg_write      = 1'b0;
    mux_write_reg  = 1'b0;
    mux_write_data = 1'b0;
    pc_write       = 1'b0;
    ir_write       = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    halted         = 1'b0;
    illegal        = 1'b0;
    if (!blank) begin
      case (state)
        FETCH: begin
          mem_read = 1'b1;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        DECODE: ;
        EXEC: alu_op = exec_alu_op;
        MEM: begin
          alu_op    = exec_alu_op;
          mem_read  = is_ld;
          mem_write = !is_ld;
        end
        WB: begin
          alu_op         = exec_alu_op;
          reg_write      = 1'b1;
          mux_write_reg  = !is_ar;
          mux_write_data = !is_ar;
        end
        HALT: halted = 1'b1;
        TRAP: illegal = illegal_flag;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multicycle_control_unit.sv
// Multicycle control unit: sequences each instruction through
// FETCH/DECODE/EXEC/MEM/WB with a memory-ready handshake and drives the
// datapath strobes via ctrl_out_decode.
// Optional feature macro: CTRL_ILLEGAL_TRAP_EN -- when defined, an illegal
// opcode or AR funct parks the FSM in TRAP with a sticky illegal flag; when
// undefined, the instruction is dropped as a NOP and illegal stays 0.
// ALUW must be >= FNW so the AR function code fits in ALUop.
module multicycle_control_unit
  import ctrl_pkg::*;
#(
  parameter int              OPW      = 5,
  parameter int              FNW      = 4,
  parameter int              ALUW     = 4,
  parameter logic [ALUW-1:0] ALU_PASS = ALUW'(ctrl_pkg::ALU_PASS)
) (
  input  logic                       clk,
  input  logic                       reset,
  multicycle_control_unit_if.master  bus,
  output state_t                     fsm_state
);

  state_t         state;
  state_t         next_state;
  logic [OPW-1:0] op_q;
  logic [FNW-1:0] fn_q;
  logic           illegal_q;
  logic           decode_bad;
  logic           in_ar;
  logic           in_legal_op;
  logic           lat_mem_op;
  logic           lat_ld;

  assign fsm_state = state;

  // Classification of the live instruction-register fields seen in DECODE.
  assign in_ar       = (bus.opcode == OPW'(OP_AR));
  assign in_legal_op = in_ar
                    || (bus.opcode == OPW'(OP_T))
                    || (bus.opcode == OPW'(OP_LD))
                    || (bus.opcode == OPW'(OP_ST))
                    || (bus.opcode == OPW'(OP_HALT));
  assign decode_bad  = !in_legal_op || (in_ar && (bus.funct > FNW'(FN_SRL)));

  // Classification of the latched opcode used after DECODE.
  assign lat_ld      = (op_q == OPW'(OP_LD));
  assign lat_mem_op  = lat_ld || (op_q == OPW'(OP_ST));

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      FETCH: if (bus.mem_ready) next_state = DECODE;
      DECODE: begin
        if (decode_bad) begin
`ifdef CTRL_ILLEGAL_TRAP_EN
          next_state = TRAP;
`else
          next_state = FETCH;
`endif
        end else if (bus.opcode == OPW'(OP_HALT)) begin
          next_state = HALT;
        end else begin
          next_state = EXEC;
        end
      end
      EXEC:    next_state = lat_mem_op ? MEM : WB;
      MEM:     if (bus.mem_ready) next_state = lat_ld ? WB : FETCH;
      WB:      next_state = FETCH;
      HALT:    next_state = HALT;
      TRAP:    next_state = TRAP;
      default: next_state = FETCH;
    endcase
  end

  // State register and DECODE-time latch of opcode/funct.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= FETCH;
      op_q  <= '0;
      fn_q  <= '0;
    end else begin
      state <= next_state;
      if (state == DECODE) begin
        op_q <= bus.opcode;
        fn_q <= bus.funct;
      end
    end
  end

`ifdef CTRL_ILLEGAL_TRAP_EN
  // Sticky illegal flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      illegal_q <= 1'b0;
    end else if (state == DECODE && decode_bad) begin
      illegal_q <= 1'b1;
    end
  end
`else
  assign illegal_q = 1'b0;
`endif

  ctrl_out_decode #(
    .OPW     (OPW),
    .FNW     (FNW),
    .ALUW    (ALUW),
    .PASS_OP (ALU_PASS)
  ) u_out_decode (
    .state          (state),
    .op             (op_q),
    .funct          (fn_q),
    .mem_ready      (bus.mem_ready),
    .illegal_flag   (illegal_q),
    .blank          (reset),
    .alu_op         (bus.ALUop),
    .reg_write      (bus.regWrite),
    .mux_write_reg  (bus.muxWriteReg),
    .mux_write_data (bus.muxWriteData),
    .pc_write       (bus.pcWrite),
    .ir_write       (bus.irWrite),
    .mem_read       (bus.memRead),
    .mem_write      (bus.memWrite),
    .halted         (bus.halted),
    .illegal        (bus.illegal)
  );

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Parametrised, clocked successor to the single-cycle combinational control decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB with a memory-ready handshake.
- Latches opcode/function code at DECODE; drives ALU, register-file, write-back mux, PC, IR and memory strobes per state.
- Sits between instruction register, datapath muxes, ALU and memory interface.

Parameters:
- OPW, 5, opcode width
- FNW, 4, function-code width (R type)
- ALUW, 4, ALUop width; must be >= FNW
- ALU_PASS, 4'b1111, ALUop for pass-through (T, LD, ST address)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- opcode  in  OPW  opcode field from instruction register
- funct  in  FNW  function field (AR only)
- mem_ready  in  1  memory completes the current read/write this cycle
- ALUop  out  ALUW  ALU operation select
- regWrite  out  1  register-file write enable
- muxWriteReg  out  1  0 = rd field, 1 = rt field
- muxWriteData  out  1  0 = ALU result, 1 = memory/immediate path
- pcWrite  out  1  PC update enable
- irWrite  out  1  instruction register load
- memRead  out  1  memory read strobe
- memWrite  out  1  memory write strobe
- halted  out  1  high while in HALT
- illegal  out  1  illegal-opcode flag (feature-dependent)

Behaviour:
- Opcodes: AR 5'b00010, T 5'b01011, LD 5'b00100, ST 5'b00101, HALT 5'b11111.
- State register changes only on the rising edge of clk. Outputs are decoded combinationally from state and the latched op/funct, so they carry no extra latency.
- reset=1 at an edge: state<=FETCH, latched op<=0, funct<=0, illegal<=0.
  - All outputs are 0 while reset is high.
  - Reset overrides any in-flight instruction, including one waiting in MEM; no write strobe survives it.
- FETCH:
  - Drives memRead=1.
  - If mem_ready: irWrite=1, pcWrite=1, next state DECODE. Otherwise stay in FETCH.
- DECODE: latch opcode/funct, then branch:
  - AR or T -> EXEC
  - LD or ST -> EXEC
  - HALT -> HALT
  - any other value -> illegal handling (see Optional Feature)
- EXEC:
  - AR: ALUop = zero-extended latched funct. funct values above 4'b1000 are illegal.
  - T/LD/ST: ALUop = ALU_PASS.
  - Next state: MEM for LD/ST, otherwise WB.
- MEM:
  - LD: memRead=1. ST: memWrite=1.
  - Hold the strobe until mem_ready. Then go to WB for LD, or to FETCH for ST.
- WB (regWrite=1):
  - AR: muxWriteReg=0, muxWriteData=0.
  - T/LD: muxWriteReg=1, muxWriteData=1.
  - Next state FETCH.
- HALT: halted=1; all strobes 0. Exit only by reset.
- Minimum cycles per instruction, with mem_ready=1 throughout: AR/T 4, ST 4, LD 5.
- mem_ready asserted outside FETCH/MEM is ignored.
- ALUop holds its EXEC value through MEM and WB, and is 0 in FETCH, DECODE and HALT.

Optional Feature:
- Macro: CTRL_ILLEGAL_TRAP_EN.
- Defined: an illegal opcode or AR funct moves to state TRAP.
  - illegal=1 (sticky) and all strobes are 0.
  - Exit only by reset.
- Undefined: the illegal instruction executes as a NOP (DECODE -> FETCH, no writes); illegal is tied to 0.

Decomposition:
- Package ctrl_pkg holds:
  - opcode and funct constants (OP_AR, OP_T, OP_LD, OP_ST, OP_HALT, FN_ADD..FN_SRL)
  - ALU_PASS
  - state enum: FETCH, DECODE, EXEC, MEM, WB, HALT, TRAP
- One natural sub-module: ctrl_out_decode, a combinational decode from {state, op, funct} to the output vector. The FSM next-state logic stays in the top.

Test Plan:
- Reset then AR with funct 4'b0011, mem_ready=1 -> states FETCH,DECODE,EXEC,WB. ALUop=4'b0011 in EXEC/WB; regWrite=1 only in cycle 4 with muxWriteReg=0, muxWriteData=0.
- T opcode -> WB cycle has regWrite=1, muxWriteReg=1, muxWriteData=1, ALUop=4'b1111.
- LD with mem_ready low 3 cycles in MEM -> memRead held 3+1 cycles; WB follows; total 8 cycles.
- ST, then reset asserted during the MEM wait -> next cycle state FETCH, memWrite=0; no regWrite.
- HALT opcode -> halted=1 from cycle 3; no further irWrite despite mem_ready=1 for 10 cycles.
- Opcode 5'b00111: with CTRL_ILLEGAL_TRAP_EN, illegal=1 and the FSM holds. Without it, returns to FETCH in cycle 3 with illegal=0.
